// File: rtl/pulse_rate_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_rate_meter_pkg
// Description : Shared widths, defaults, phase encoding and a saturating
//               increment helper for the pulse rate meter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_rate_meter_pkg;

   // Published count width; covers 0..999 for the 3-digit display.
   localparam int DATA_W         = 10;
   localparam int MAX_COUNT_DEF  = 999;
   localparam int GATE_TICKS_DEF = 1000;

   // Per-window phase, derived from the gate counter.
   typedef enum logic {
      PH_COUNT = 1'b0,
      PH_CLOSE = 1'b1
   } phase_e;

   // Increment by one on inc, but never beyond maxv and never wrap.
   function automatic logic [DATA_W-1:0] sat_inc(
      input logic [DATA_W-1:0] v,
      input logic              inc,
      input logic [DATA_W-1:0] maxv
   );
      logic [DATA_W-1:0] r;
      r = v;
      if (inc && (v < maxv)) begin
         r = v + 1'b1;
      end
      return r;
   endfunction

endpackage : pulse_rate_meter_pkg
`default_nettype wire

// File: rtl/pulse_rate_meter_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer followed by a rising-edge detector.
//               Usable for any slow asynchronous input (events, buttons).
// Revision    : 1.0 - initial release
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               d_async - asynchronous input
//               rise    - one-cycle pulse, synchronized rising edge of d_async
// ============================================================================
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic rise
);

   logic s1_q;
   logic s2_q;
   logic p_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         p_q  <= 1'b0;
      end else begin
         s1_q <= d_async;
         s2_q <= s1_q;
         p_q  <= s2_q;
      end
   end

   // p_q clears in reset, so an input already high at release reads as an edge.
   assign rise = s2_q & ~p_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/pulse_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_rate_meter
// Description : Counts synchronized rising edges of sig_in over a fixed gate
//               window of GATE_TICKS clocks and publishes the saturated count
//               (0..MAX_COUNT) plus an overflow flag at each window close.
// Revision    : 1.0 - initial release
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset
//               sig_in - asynchronous event input
//               hold   - freezes data/ovf at window close while high
//               data   - last published count
//               ovf    - last published window exceeded MAX_COUNT
//               valid  - one-cycle strobe coincident with a data/ovf update
// ============================================================================
module pulse_rate_meter
   import pulse_rate_meter_pkg::*;
#(
   parameter int GATE_TICKS = GATE_TICKS_DEF,
   parameter int MAX_COUNT  = MAX_COUNT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sig_in,
   input  logic              hold,
   output logic [DATA_W-1:0] data,
   output logic              ovf,
   output logic              valid
);

   localparam int                CNT_W     = $clog2(GATE_TICKS);
   localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(GATE_TICKS - 1);
   localparam logic [DATA_W-1:0] MAX_VAL   = DATA_W'(MAX_COUNT);

   logic              rise;
   phase_e            phase;

   logic [CNT_W-1:0]  gate_cnt_q, gate_cnt_d;
   logic [DATA_W-1:0] acc_q,      acc_d;
   logic              acc_ovf_q,  acc_ovf_d;
   logic [DATA_W-1:0] data_q,     data_d;
   logic              ovf_q,      ovf_d;
   logic              valid_q,    valid_d;

   // Window view including this cycle's edge; this is what a close publishes.
   logic [DATA_W-1:0] acc_incl;
   logic              ovf_incl;

   sync_edge u_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .d_async (sig_in),
      .rise    (rise)
   );

   always_comb begin
      phase      = (gate_cnt_q == LAST_TICK) ? PH_CLOSE : PH_COUNT;
      acc_incl   = sat_inc(acc_q, rise, MAX_VAL);
      ovf_incl   = acc_ovf_q | (rise & (acc_q == MAX_VAL));

      gate_cnt_d = gate_cnt_q + 1'b1;
      acc_d      = acc_incl;
      acc_ovf_d  = ovf_incl;
      data_d     = data_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;

      if (phase == PH_CLOSE) begin
         gate_cnt_d = '0;
         acc_d      = '0;
         acc_ovf_d  = 1'b0;
         // A held close discards the window; the counter keeps running.
         if (!hold) begin
            data_d  = acc_incl;
            ovf_d   = ovf_incl;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt_q <= '0;
         acc_q      <= '0;
         acc_ovf_q  <= 1'b0;
         data_q     <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         acc_q      <= acc_d;
         acc_ovf_q  <= acc_ovf_d;
         data_q     <= data_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign data  = data_q;
   assign ovf   = ovf_q;
   assign valid = valid_q;

endmodule : pulse_rate_meter
`default_nettype wire

// File: tb/tb_pulse_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_rate_meter
// Description : Directed self-checking bench for pulse_rate_meter. One
//               instance uses a 1000-tick gate, a second a 4000-tick gate
//               for the saturation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_rate_meter;

   localparam int G  = 1000;
   localparam int GS = 4000;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       sig_in = 1'b0;
   logic       hold   = 1'b0;
   logic [9:0] data;
   logic       ovf;
   logic       valid;

   logic       rst_s  = 1'b1;
   logic       sig_s  = 1'b0;
   logic       hold_s = 1'b0;
   logic [9:0] data_s;
   logic       ovf_s;
   logic       valid_s;

   int vectors     = 0;
   int miscompares = 0;
   int pos         = 0;   // cycle index within the current G window

   always #5 clk = ~clk;

   pulse_rate_meter #(.GATE_TICKS(G), .MAX_COUNT(999)) dut (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .hold   (hold),
      .data   (data),
      .ovf    (ovf),
      .valid  (valid)
   );

   pulse_rate_meter #(.GATE_TICKS(GS), .MAX_COUNT(999)) dut_s (
      .clk    (clk),
      .rst    (rst_s),
      .sig_in (sig_s),
      .hold   (hold_s),
      .data   (data_s),
      .ovf    (ovf_s),
      .valid  (valid_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      pos = (pos == G - 1) ? 0 : pos + 1;
   endtask

   // Always advances at least one cycle, stops when pos reaches p.
   task automatic run_to(input int p);
      do tick(); while (pos != p);
   endtask

   task automatic pulse(input int n);
      repeat (n) begin
         sig_in = 1'b1; tick(); tick();
         sig_in = 1'b0; tick(); tick();
      end
   endtask

   task automatic pulse_s(input int n);
      repeat (n) begin
         sig_s = 1'b1; tick(); tick();
         sig_s = 1'b0; tick(); tick();
      end
   endtask

   initial begin
      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_data",  data,  0);
      check("rst_ovf",   ovf,   0);
      check("rst_valid", valid, 0);

      // ---- reset asserted mid-window with pulses present
      rst = 1'b0; pos = 0;
      pulse(75);
      sig_in = 1'b1;
      rst    = 1'b1;
      #1;
      check("midrst_data",  data,  0);
      check("midrst_valid", valid, 0);
      tick(); tick();
      sig_in = 1'b0;
      tick(); tick();
      rst = 1'b0; pos = 0;

      // ---- nominal: 250 pulses in the first window after release
      pulse(249);
      sig_in = 1'b1; tick(); tick();
      sig_in = 1'b0; tick();
      check("valid_before_close", valid, 0);
      tick();
      check("first_valid", valid, 1);
      check("nom_data",    data,  250);
      check("nom_ovf",     ovf,   0);
      tick();
      check("valid_one_cycle", valid, 0);
      check("data_stable",     data,  250);

      // ---- empty window
      run_to(0);
      check("empty_valid", valid, 1);
      check("empty_data",  data,  0);

      // ---- boundary: edge visible in the close cycle joins the closing window
      pulse(5);
      run_to(G - 3);
      sig_in = 1'b1; tick(); tick();
      sig_in = 1'b0; tick();
      check("edge_at_close", data, 6);

      // ---- boundary: rise one cycle before close lands in the next window
      run_to(G - 2);
      sig_in = 1'b1; tick(); tick();
      check("late_rise_excluded", data, 0);
      sig_in = 1'b0;
      run_to(0);
      check("late_rise_next", data, 1);

      // ---- hold across a close discards that window
      hold = 1'b1;
      pulse(40);
      run_to(G - 1);
      check("hold_valid_pre", valid, 0);
      tick();
      check("hold_valid", valid, 0);
      check("hold_data",  data,  1);

      // ---- released hold; toggling hold mid-window does not disturb counting
      hold = 1'b0;
      pulse(40);
      hold = 1'b1;
      repeat (50) tick();
      hold = 1'b0;
      run_to(0);
      check("after_hold_valid", valid, 1);
      check("after_hold_data",  data,  40);
      check("after_hold_ovf",   ovf,   0);

      // ---- reset during counting leaves no residue
      pulse(100);
      rst = 1'b1;
      #1;
      check("cnt_rst_data",  data,  0);
      check("cnt_rst_valid", valid, 0);
      tick();
      rst = 1'b0; pos = 0;
      pulse(30);
      run_to(0);
      check("post_rst_valid", valid, 1);
      check("post_rst_data",  data,  30);

      // ---- saturation on the 4000-tick instance
      check("sat_rst_data", data_s, 0);
      rst_s = 1'b0;
      pulse_s(1000);
      check("sat_valid", valid_s, 1);
      check("sat_data",  data_s,  999);
      check("sat_ovf",   ovf_s,   1);
      pulse_s(10);
      repeat (GS - 40) tick();
      check("unsat_valid", valid_s, 1);
      check("unsat_data",  data_s,  10);
      check("unsat_ovf",   ovf_s,   0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pulse_rate_meter
`default_nettype wire
